// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//   Shares one WIDTH-bit ALU between two requesters. Requests arrive on
//   per-requester valid/ready channels and are granted round-robin. A legal
//   op is presented to the ALU (alu_status high) for ALU_LATENCY cycles and
//   its result/flags are captured in the last of those cycles. The captured
//   response is returned to the owning requester over rsp_valid/rsp_ready.
//   Illegal opcodes (op[2]==0) skip the ALU and answer with err=1.
//
// Ports
//   clk, rst_n                      clock / async active-low reset
//   req_valid[1:0], req_ready[1:0]  request handshake, bit i = requester i
//   req{0,1}_a/_b/_op               request operands and opcode
//   rsp_valid[1:0], rsp_ready[1:0]  response handshake
//   rsp_result/cout/ovf/err         captured response, shared by both channels
//   alu_status, alu_a/b/opcode      ALU drive (all 0 outside EXEC)
//   alu_result/cout/overflow        ALU outputs
//   busy                            high outside IDLE
//   op_count                        completed responses, wraps
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             alu_status,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             err;
  } rsp_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LATENCY);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;      // favoured requester when both are valid
  logic             owner_q, owner_d;  // requester that owns the in-flight op
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stat_q, stat_d;
  req_t             alu_q, alu_d;      // doubles as the latched request; zeroed outside EXEC
  rsp_t             rsp_q, rsp_d;
  logic [1:0]       rv_q, rv_d;

  req_t [1:0] req_in;
  logic       gnt;

  assign req_in[0] = '{a: req0_a, b: req0_b, op: req0_op};
  assign req_in[1] = '{a: req1_a, b: req1_b, op: req1_op};

  // A lone valid requester wins regardless of the pointer.
  assign gnt = (&req_valid) ? ptr_q : req_valid[1];

  // Reset gating keeps req_ready low while rst_n is held, even though the
  // FSM already sits in IDLE.
  assign req_ready = (rst_n && state_q == IDLE && |req_valid) ? (2'b01 << gnt) : 2'b00;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
    alu_d   = alu_q;
    rsp_d   = rsp_q;
    rv_d    = rv_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = gnt;
          if (req_in[gnt].op[2]) begin
            state_d = EXEC;
            lat_d   = LAT4;
            alu_d   = req_in[gnt];
            stat_d  = 1'b1;
          end else begin
            // Illegal opcode: answer immediately, ALU never enabled.
            state_d = RESP;
            rsp_d   = '{result: '0, cout: 1'b0, ovf: 1'b0, err: 1'b1};
            rv_d    = 2'b01 << gnt;
          end
        end
      end
      EXEC: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          rsp_d   = '{result: alu_result, cout: alu_cout, ovf: alu_overflow, err: 1'b0};
          stat_d  = 1'b0;
          alu_d   = '0;
          rv_d    = 2'b01 << owner_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rv_d    = 2'b00;
          cnt_d   = cnt_q + 1'b1;
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      lat_q   <= '0;
      cnt_q   <= '0;
      stat_q  <= 1'b0;
      alu_q   <= '0;
      rsp_q   <= '0;
      rv_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      alu_q   <= alu_d;
      rsp_q   <= rsp_d;
      rv_q    <= rv_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign alu_status = stat_q;
  assign alu_a      = alu_q.a;
  assign alu_b      = alu_q.b;
  assign alu_opcode = alu_q.op;
  assign rsp_valid  = rv_q;
  assign rsp_result = rsp_q.result;
  assign rsp_cout   = rsp_q.cout;
  assign rsp_ovf    = rsp_q.ovf;
  assign rsp_err    = rsp_q.err;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Main instance: ALU_LATENCY=3, CNT_W=4, with a bench ALU that only gives
//   the right answer once alu_status has been high for ALU_LATENCY cycles.
//   Second instance: ALU_LATENCY=1 for the single-cycle add case.
//   A transaction-level model (accept time, response time, pointer, count)
//   predicts every main-instance output each cycle; directed literal checks
//   pin the model on the hand-worked cases.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
  localparam int LAT  = 3;
  localparam int CNTW = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } alu_t;

  function automatic alu_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    alu_t r;
    logic [32:0] s;
    r = '0;
    s = '0;
    case (op)
      4'hF: begin s = {1'b0, a} + {1'b0, b};  r.res = s[31:0]; r.co = s[32]; r.ov = (a[31] == b[31]) && (r.res[31] != a[31]); end
      4'hE: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r.res = s[31:0]; r.co = s[32]; r.ov = (a[31] != b[31]) && (r.res[31] != a[31]); end
      4'hD: begin s = {1'b0, a} + 33'd1; r.res = s[31:0]; r.co = s[32]; r.ov = (a == 32'h7FFF_FFFF); end
      4'hC: begin s = {1'b0, a} + {1'b0, 32'hFFFF_FFFF}; r.res = s[31:0]; r.co = s[32]; r.ov = (a == 32'h8000_0000); end
      4'h7: r.res = a & b;
      4'h6: r.res = a | b;
      4'h5: r.res = a ^ b;
      4'h4: r.res = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [1:0]  req_valid = 2'b00, rsp_ready = 2'b00;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_cout, rsp_ovf, rsp_err, alu_status, alu_cout, alu_overflow, busy;
  logic [3:0]  alu_opcode;
  logic [CNTW-1:0] op_count;

  alu_share_ctrl #(.WIDTH(32), .ALU_LATENCY(LAT), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_status(alu_status), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .busy(busy), .op_count(op_count));

  // Bench ALU: wrong (inverted) outputs until alu_status has been high for LAT cycles.
  int   stat_hi = 0;
  alu_t mr;
  assign mr           = alu_ref(alu_a, alu_b, alu_opcode);
  assign alu_result   = (stat_hi >= LAT) ? mr.res : ~mr.res;
  assign alu_cout     = (stat_hi >= LAT) ? mr.co  : ~mr.co;
  assign alu_overflow = (stat_hi >= LAT) ? mr.ov  : ~mr.ov;

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) stat_hi = 0;
    else        stat_hi = alu_status ? stat_hi + 1 : 0;
  end

  // ---------------- LAT=1 instance ----------------
  logic [1:0]  s_valid = 2'b00, s_rsp_ready = 2'b00;
  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [31:0] s_a = '0, s_b = '0, zero32 = '0;
  logic [3:0]  s_op = '0, zero4 = '0;
  logic [31:0] s_result, s_alu_a, s_alu_b;
  logic        s_cout, s_ovf, s_err, s_status, s_busy;
  logic [3:0]  s_alu_op;
  logic [15:0] s_cnt;
  alu_t        sr;
  assign sr = alu_ref(s_alu_a, s_alu_b, s_alu_op);

  alu_share_ctrl #(.WIDTH(32), .ALU_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_req_ready),
    .req0_a(s_a), .req0_b(s_b), .req0_op(s_op),
    .req1_a(zero32), .req1_b(zero32), .req1_op(zero4),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_result(s_result),
    .rsp_cout(s_cout), .rsp_ovf(s_ovf), .rsp_err(s_err),
    .alu_status(s_status), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_opcode(s_alu_op),
    .alu_result(sr.res), .alu_cout(sr.co), .alu_overflow(sr.ov),
    .busy(s_busy), .op_count(s_cnt));

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model of the main instance.
  int          cyc = 0;
  bit          m_act = 0, m_legal = 0, m_own = 0, m_ptr = 0;
  int          m_resp_at = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0;
  alu_t        m_r = '0;
  int          m_cnt = 0, m_done = 0;
  logic [1:0]  m_took = 2'b00;
  int          gq[$];
  int          oq[$];

  function automatic bit pick(input logic [1:0] v, input bit ptr);
    return (v == 2'b11) ? ptr : v[1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_ptr = 0; m_cnt = 0; m_took = 2'b00;
    end else begin
      bit g;
      m_took = 2'b00;
      if (!m_act && req_valid != 2'b00) begin
        g = pick(req_valid, m_ptr);
        m_own = g; m_took[g] = 1'b1; gq.push_back(int'(g));
        m_a  = g ? req1_a  : req0_a;
        m_b  = g ? req1_b  : req0_b;
        m_op = g ? req1_op : req0_op;
        m_legal = m_op[2];
        m_r = m_legal ? alu_ref(m_a, m_b, m_op) : '0;
        m_act = 1;
        m_resp_at = cyc + 1 + (m_legal ? LAT : 0);
      end else if (m_act && cyc >= m_resp_at && rsp_ready[m_own]) begin
        m_act = 0;
        m_cnt = (m_cnt + 1) % (1 << CNTW);
        m_ptr = !m_own;
        m_done++;
        oq.push_back(int'(m_own));
      end
      cyc++;
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    logic [1:0]  e_rdy, e_rv;
    logic        e_stat;
    logic [1:0]  one;
    @(negedge clk);
    one    = 2'b01;
    e_rdy  = (rst_n && !m_act && req_valid != 2'b00) ? (one << pick(req_valid, m_ptr)) : 2'b00;
    e_stat = m_act && m_legal && (cyc < m_resp_at);
    e_rv   = (m_act && cyc >= m_resp_at) ? (one << m_own) : 2'b00;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("busy", 64'(busy), 64'(m_act));
    chk("alu_status", 64'(alu_status), 64'(e_stat));
    chk("alu_a", 64'(alu_a), e_stat ? 64'(m_a) : 64'd0);
    chk("alu_b", 64'(alu_b), e_stat ? 64'(m_b) : 64'd0);
    chk("alu_opcode", 64'(alu_opcode), e_stat ? 64'(m_op) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    if (e_rv != 2'b00) begin
      chk("rsp_result", 64'(rsp_result), 64'(m_r.res));
      chk("rsp_cout", 64'(rsp_cout), 64'(m_r.co));
      chk("rsp_ovf", 64'(rsp_ovf), 64'(m_r.ov));
      chk("rsp_err", 64'(rsp_err), 64'(!m_legal));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] corner [4];
    corner = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    op = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0) op[2] = 1'b1;
    if (i == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
  endtask

  // Let any pending requests be accepted and all responses complete.
  task automatic drain();
    int n;
    rsp_ready = 2'b11;
    for (n = 0; n < 100; n++) begin
      for (int i = 0; i < 2; i++) if (m_took[i]) req_valid[i] = 1'b0;
      if (req_valid == 2'b00 && !m_act) break;
      step();
    end
    chk("drain_in_bound", 64'(n < 100), 64'd1);
    rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int  done0, n;
    bit  seen4;

    // Reset state.
    step(); step();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_status", 64'(alu_status), 64'd0);
    chk("rst_l1_busy", 64'(s_busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // LAT=1: 0xFFFFFFFF + 1 -> 0, cout=1, response two cycles after accept.
    s_a = 32'hFFFF_FFFF; s_b = 32'h1; s_op = 4'hF; s_valid = 2'b01;
    @(negedge clk);
    chk("l1_req_ready", 64'(s_req_ready), 64'h1);
    step();
    s_valid = 2'b00;
    @(negedge clk);
    chk("l1_status_t1", 64'(s_status), 64'h1);
    chk("l1_alu_a_t1", 64'(s_alu_a), 64'hFFFF_FFFF);
    chk("l1_rsp_valid_t1", 64'(s_rsp_valid), 64'h0);
    step();
    s_rsp_ready = 2'b01;
    @(negedge clk);
    chk("l1_rsp_valid_t2", 64'(s_rsp_valid), 64'h1);
    chk("l1_result", 64'(s_result), 64'h0);
    chk("l1_cout", 64'(s_cout), 64'h1);
    chk("l1_ovf", 64'(s_ovf), 64'h0);
    chk("l1_err", 64'(s_err), 64'h0);
    chk("l1_status_t2", 64'(s_status), 64'h0);
    step();
    s_rsp_ready = 2'b00;
    @(negedge clk);
    chk("l1_op_count", 64'(s_cnt), 64'h1);
    chk("l1_busy_after", 64'(s_busy), 64'h0);
    step();

    // Illegal opcode from requester 1: answered the next cycle, err=1.
    req1_a = 32'h1234_5678; req1_b = 32'h9ABC_DEF0; req1_op = 4'b1011; req_valid = 2'b10;
    @(negedge clk);
    chk("ill_req_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    chk("ill_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("ill_result", 64'(rsp_result), 64'h0);
    chk("ill_err", 64'(rsp_err), 64'h1);
    chk("ill_status", 64'(alu_status), 64'h0);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("ill_op_count", 64'(op_count), 64'h1);
    chk("ill_busy", 64'(busy), 64'h0);
    step();

    // AND with response backpressure; requester 1 waits behind it.
    req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 4'b0111; req_valid = 2'b01;
    @(negedge clk);
    chk("bp_req_ready0", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b10; req1_a = 32'd5; req1_b = 32'd7; req1_op = 4'hF;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("bp_ready_exec", 64'(req_ready), 64'h0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_result", 64'(rsp_result), 64'hF000_F000);
      chk("bp_ready_resp", 64'(req_ready), 64'h0);
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_result_hs", 64'(rsp_result), 64'hF000_F000);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_req1_granted", 64'(req_ready), 64'h2);
    step();
    drain();

    // Reset in the second EXEC cycle; pointer is first steered to requester 1.
    rand_req(0); req0_op = 4'hF; req_valid = 2'b01;
    drain();
    rand_req(0); req0_op = 4'hE; req_valid = 2'b01;
    @(negedge clk);
    chk("rst_lone_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_exec1_status", 64'(alu_status), 64'h1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_status", 64'(alu_status), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_alu_a", 64'(alu_a), 64'h0);
    chk("mid_rst_opcode", 64'(alu_opcode), 64'h0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_op_count", 64'(op_count), 64'h0);
    chk("mid_rst_result", 64'(rsp_result), 64'h0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'h0);
      step();
    end

    // Both valid continuously, responses taken at once: alternating grants, count wraps.
    gq.delete(); oq.delete();
    done0 = m_done; seen4 = 0;
    rand_req(0); rand_req(1); req_valid = 2'b11; rsp_ready = 2'b11;
    for (n = 0; n < 300 && (m_done - done0) < 17; n++) begin
      @(negedge clk);
      if (n == 0) chk("alt_first_grant", 64'(req_ready), 64'h1);
      if (!seen4 && (m_done - done0) == 4) begin
        seen4 = 1;
        chk("alt_op_count4", 64'(op_count), 64'h4);
        for (int k = 0; k < 4; k++) begin
          chk("alt_grant", 64'(gq[k]), 64'(k % 2));
          chk("alt_owner", 64'(oq[k]), 64'(k % 2));
        end
      end
      step();
      for (int i = 0; i < 2; i++) if (m_took[i]) rand_req(i);
    end
    chk("ops17_in_bound", 64'(n < 300), 64'd1);
    @(negedge clk);
    chk("op_count_wrap17", 64'(op_count), 64'h1);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_took[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          rand_req(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      step();
    end
    drain();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares one 32-bit ALU instance between two requesters.
- Accepts operations over per-requester valid/ready channels and arbitrates round-robin.
- Drives the ALU enable, operand and opcode inputs, waits a fixed settle latency, then captures result/cout/overflow.
- Returns the captured values to the owning requester over a valid/ready response channel. Sits between the ALU and its client blocks.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- ALU_LATENCY, 1, cycles alu_status is held high before the result is sampled; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH each  operands.
- req0_op / req1_op  in  4  ALU opcode.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  captured result, shared by both channels.
- rsp_cout  out  1  captured carry.
- rsp_ovf  out  1  captured overflow.
- rsp_err  out  1  opcode was illegal.
- alu_status  out  1  ALU enable.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_opcode  out  4  ALU opcode.
- alu_result  in  WIDTH  ALU result.
- alu_cout, alu_overflow  in  1 each  ALU flags.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed responses; wraps to 0.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 favoured), op_count = 0.
- Reset mid-operation: any in-flight operation is dropped and no response is issued.
- Opcode legality: legal opcodes have op[2]=1, i.e. 1111 add, 1110 sub, 1101 inc, 1100 dec, 0111 and, 0110 or, 0101 xor, 0100 not. Any opcode with op[2]=0 is illegal.
- Request rule: requesters hold valid and operands stable until ready is seen.
- IDLE:
  - alu_status=0.
  - Grant = requester whose valid is high; if both are high, grant = pointer.
  - req_ready[grant]=1 combinationally in IDLE only; both bits are never 1 together.
  - On valid&ready, latch a, b, op and owner id.
  - Legal op: go to EXEC with latency counter = ALU_LATENCY.
  - Illegal op: go directly to RESP with result=0, cout=0, ovf=0, err=1; the ALU is never enabled.
- EXEC:
  - alu_status=1; alu_a/alu_b/alu_opcode driven from the latched registers, stable for the whole state.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, register alu_result/alu_cout/alu_overflow into the response registers with err=0, then go to RESP.
  - alu_status returns to 0 on exit.
- RESP:
  - rsp_valid[owner]=1; the other rsp_valid bit stays 0.
  - rsp_result/cout/ovf/err hold stable until rsp_ready[owner]=1.
  - On handshake: op_count += 1 (wraps), pointer = other requester, state = IDLE.
  - rsp_ready on the non-owner bit is ignored.
- ALU outputs outside EXEC: alu_a, alu_b and alu_opcode are 0.
- Latency: a legal op accepted at cycle T has rsp_valid at T+ALU_LATENCY+1; an illegal op has rsp_valid at T+1.
- Throughput: at most one operation every ALU_LATENCY+2 cycles (legal op, no backpressure). A new request can be accepted in the first IDLE cycle after the response handshake.
- Busy: busy=1 in EXEC and RESP; no request is accepted while busy.
- Single requester: a lone valid requester is granted regardless of pointer. Pointer changes only on response handshake.

Test Plan:
- ALU_LATENCY=1, model ALU attached; req0 op=1111, a=0xFFFFFFFF, b=1 accepted at T -> at T+2 rsp_valid=01, result=0x00000000, cout=1, err=0; op_count=1 after handshake.
- req_valid=11 held continuously, each response taken immediately -> grants alternate 0,1,0,1; response owners match; op_count=4 after four ops.
- req1 op=1011 -> rsp_valid=10 one cycle after accept, result=0, err=1; alu_status never high.
- req0 op=0111, a=0xF0F0F0F0, b=0xFF00FF00; rsp_ready held low 5 cycles -> result 0xF000F000 stable throughout; req_ready stays 00 while req1 is valid; req1 is granted after the handshake.
- ALU_LATENCY=3; assert rst_n=0 in the second EXEC cycle -> all outputs 0 immediately; after release, no rsp_valid; pointer favours req0.
- CNT_W=4; complete 17 ops -> op_count reads 1.
